collision_detector: RTL
=======================

// Module: collision_detector
// PURPOSE
//  Reads the per-pixel draw flags that sprite units (torpedoes, rocks, ship) emit on the VGA chain.
//  Latches per-frame overlaps and resolves them at vsync into hit pulses and a handshaked event stream.
//  Hit pulses feed back into the sprite units' collision inputs. The event stream feeds the score unit.
// PARAMETERS
//  TORPEDOS  2  number of torpedo layers (1..4)
//  ROCKS     8  number of rock layers (1..16)
// PORTS
//  clk        in   1           system clock (single clock domain)
//  reset      in   1           synchronous, active-high reset
//  vsync      in   1           frame-start strobe, already a 1-cycle pulse
//  pix_valid  in   1           current pixel is in active video
//  torp_draw  in   TORPEDOS    torpedo i draws a non-transparent pixel this cycle
//  rock_draw  in   ROCKS       rock j draws a non-transparent pixel this cycle
//  ship_draw  in   1           ship draws a non-transparent pixel (used only with macro)
//  torp_hit   out  TORPEDOS    1-cycle pulses, one per torpedo resolved as hit
//  rock_hit   out  ROCKS       1-cycle pulses, one per rock resolved as hit
//  ship_hit   out  1           1-cycle pulse (tied 0 without macro)
//  ev_valid   out  1           hit event available
//  ev_ready   in   1           consumer accepts event
//  ev_torp    out  $clog2(TORPEDOS)+1   torpedo index of event
//  ev_rock    out  $clog2(ROCKS)+1      rock index of event
//  busy       out  1           FSM not in IDLE
//  overrun    out  1           sticky flag: vsync arrived while busy
// BEHAVIOUR
//  - Reset: all outputs 0, accumulator and snapshot cleared, FSM = IDLE. Reset mid-scan drops all events.
//  - Accumulate: acc[i][j] |= pix_valid & torp_draw[i] & rock_draw[j] on every cycle. Sticky for the frame.
//  - vsync cycle: snap <= acc, then acc is cleared. A same-cycle overlap is written into the new acc,
//    so it belongs to the next frame.
//  - FSM states: IDLE -> SCAN on vsync. SCAN -> PULSE -> DRAIN -> IDLE.
//  - SCAN: visits one (i,j) pair per cycle, i-major, i=0..TORPEDOS-1, j=0..ROCKS-1; lasts TORPEDOS*ROCKS cycles.
//    Pair (i,j) is a hit if snap[i][j] is set and neither torpedo i nor rock j has already been claimed.
//    On a hit: claim both and push {i,j} into the event FIFO (depth = min(TORPEDOS,ROCKS)).
//    Result: each torpedo matches at most its lowest-index free rock, and each rock is matched at most once.
//  - PULSE: single cycle; torp_hit and rock_hit equal the claim vectors.
//  - DRAIN: ev_valid = FIFO non-empty. Transfer when ev_valid & ev_ready.
//    ev_torp and ev_rock hold steady while ev_valid=1 and ev_ready=0. Go to IDLE when FIFO is empty.
//  - Zero-hit frame: SCAN -> PULSE with all pulses 0 -> DRAIN -> IDLE. ev_valid stays 0.
//  - vsync while busy: overrun <= 1, sticky until reset. FSM aborts, FIFO is flushed and claims are cleared.
//    Restart in SCAN with the fresh snapshot; the same vsync already took it.
//  - Latency: first pulse = TORPEDOS*ROCKS+1 cycles after vsync. First ev_valid comes one cycle later.
//  - Widths: scan counters wrap at parameter limits, not at power-of-2. Index outputs are zero-extended.
// CONFIGURATION
//  - Macro SHIP_COLLISION_EN defined:
//    shipacc |= pix_valid & ship_draw & |rock_draw. It is snapshotted and cleared like acc.
//    ship_hit pulses in PULSE if the snapshot is set. Ship overlap never claims a rock and produces no event.
//  - Macro undefined: ship_draw is ignored and ship_hit is constant 0.
// TESTING
//  - Torp 0 and rock 3 overlap on 1 pixel; vsync; ev_ready=1 -> torp_hit=01 and rock_hit=0x08 after 17 cycles.
//    Then one event {0,3}, then IDLE.
//  - Torps 0 and 1 both overlap rock 2 only -> torp_hit=01, rock_hit=0x04, exactly 1 event {0,2}.
//  - Torp 0 overlaps rocks 1 and 5; torp 1 overlaps rock 1 -> events {0,1}; torp 1 not hit;
//    rock_hit=0x02; no event for rock 5.
//  - Overlap asserted with pix_valid=0, and overlap on the same cycle as vsync -> no hit this frame.
//    The vsync-cycle overlap is reported at the following vsync.
//  - 2 events pending, ev_ready held 0 for 10 cycles, then a second vsync -> overrun=1, FIFO flushed.
//    New scan reports the new frame only. Reset then clears overrun.
//  - With SHIP_COLLISION_EN: ship_draw & rock_draw[7] -> ship_hit pulse, rock_hit=0, no event.
//    Without the macro: ship_hit stays 0.

Source files
------------

// File: rtl/collision_detector_if.sv
// Hit-event stream between the collision detector and the score unit.
// The master side presents {ev_torp, ev_rock} with ev_valid; the slave
// side accepts with ev_ready. Index widths follow the detector parameters.
interface collision_detector_if #(
    parameter int TORPEDOS = 2,
    parameter int ROCKS    = 8
);
    localparam int TW = $clog2(TORPEDOS) + 1;
    localparam int RW = $clog2(ROCKS) + 1;

    logic          ev_valid;
    logic          ev_ready;
    logic [TW-1:0] ev_torp;
    logic [RW-1:0] ev_rock;

    modport master (
        output ev_valid,
        output ev_torp,
        output ev_rock,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_torp,
        input  ev_rock,
        output ev_ready
    );
endinterface

// File: rtl/collision_detector.sv
// collision_detector
// Watches the per-pixel draw flags of the torpedo and rock sprite units,
// latches every torpedo/rock overlap seen during a frame, and at vsync
// resolves the frame's overlaps into one-cycle hit pulses plus a handshaked
// stream of {torpedo, rock} events for the score unit.
//
// Optional feature: define SHIP_COLLISION_EN to also latch ship/rock
// overlaps and pulse o_ship_hit. Ship hits never claim a rock and never
// produce an event. Without the macro i_ship_draw is ignored and
// o_ship_hit is constant 0.
module collision_detector #(
    parameter int TORPEDOS = 2,
    parameter int ROCKS    = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_vsync,
    input  logic                i_pix_valid,
    input  logic [TORPEDOS-1:0] i_torp_draw,
    input  logic [ROCKS-1:0]    i_rock_draw,
    input  logic                i_ship_draw,
    output logic [TORPEDOS-1:0] o_torp_hit,
    output logic [ROCKS-1:0]    o_rock_hit,
    output logic                o_ship_hit,
    collision_detector_if.master ev_if,
    output logic                o_busy,
    output logic                o_overrun
);
    localparam int TW    = $clog2(TORPEDOS) + 1;
    localparam int RW    = $clog2(ROCKS) + 1;
    localparam int PAIRS = TORPEDOS * ROCKS;
    localparam int PIW   = $clog2(PAIRS) + 1;
    // At most one event per torpedo and one per rock, so this many slots suffice.
    localparam int DEPTH = (TORPEDOS < ROCKS) ? TORPEDOS : ROCKS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << AW;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_PULSE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Overlap matrices are flattened i-major: bit i*ROCKS+j is torpedo i vs rock j.
    logic [PAIRS-1:0]    r_acc;
    logic [PAIRS-1:0]    r_snap;
    logic [PAIRS-1:0]    w_ovl;

    state_t              r_state;
    logic [PIW-1:0]      r_pidx;
    logic [TW-1:0]       r_ti;
    logic [RW-1:0]       r_rj;
    logic [TORPEDOS-1:0] r_tclaim;
    logic [ROCKS-1:0]    r_rclaim;

    logic [TW-1:0]       r_fifo_t [SLOTS];
    logic [RW-1:0]       r_fifo_r [SLOTS];
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [CW-1:0]       r_cnt;

    logic [TORPEDOS-1:0] r_torp_hit;
    logic [ROCKS-1:0]    r_rock_hit;
    logic                r_ship_hit;
    logic                r_ev_valid;
    logic [TW-1:0]       r_ev_torp;
    logic [RW-1:0]       r_ev_rock;
    logic                r_overrun;

    logic [TORPEDOS-1:0] w_tsel;
    logic [ROCKS-1:0]    w_rsel;
    logic [PAIRS-1:0]    w_psel;
    logic                w_hit;
    logic                w_push;
    logic [TORPEDOS-1:0] w_tclaim_nxt;
    logic [ROCKS-1:0]    w_rclaim_nxt;
    logic [AW-1:0]       w_wr_nxt;
    logic [AW-1:0]       w_rd_nxt;
    logic                w_ship_snap;

`ifdef SHIP_COLLISION_EN
    logic r_ship_acc;
    logic r_ship_snap;
    logic w_ship_ovl;

    // Ship overlaps any drawn rock on a visible pixel.
    always_comb begin
        w_ship_ovl = i_pix_valid & i_ship_draw & (|i_rock_draw);
    end

    // Ship accumulator: sticky over the frame, snapshotted and restarted at vsync.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ship_acc  <= 1'b0;
            r_ship_snap <= 1'b0;
        end else if (i_vsync) begin
            r_ship_snap <= r_ship_acc;
            r_ship_acc  <= w_ship_ovl;
        end else begin
            r_ship_acc  <= r_ship_acc | w_ship_ovl;
        end
    end

    assign w_ship_snap = r_ship_snap;
`else
    logic w_unused_ship;
    assign w_unused_ship = i_ship_draw;
    assign w_ship_snap   = 1'b0;
`endif

    // Per-pixel torpedo/rock overlap matrix, masked by active video.
    always_comb begin
        w_ovl = '0;
        for (int i = 0; i < TORPEDOS; i++) begin
            for (int j = 0; j < ROCKS; j++) begin
                w_ovl[i*ROCKS + j] = i_pix_valid & i_torp_draw[i] & i_rock_draw[j];
            end
        end
    end

    // Frame accumulator: sticky ORs; vsync takes the snapshot and the
    // same-cycle overlap seeds the next frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc  <= '0;
            r_snap <= '0;
        end else if (i_vsync) begin
            r_snap <= r_acc;
            r_acc  <= w_ovl;
        end else begin
            r_acc  <= r_acc | w_ovl;
        end
    end

    // One-hot decode of the current scan position (avoids variable bit-selects).
    always_comb begin
        w_tsel = '0;
        w_rsel = '0;
        w_psel = '0;
        for (int i = 0; i < TORPEDOS; i++) begin
            w_tsel[i] = (r_ti == TW'(i));
        end
        for (int j = 0; j < ROCKS; j++) begin
            w_rsel[j] = (r_rj == RW'(j));
        end
        for (int k = 0; k < PAIRS; k++) begin
            w_psel[k] = (r_pidx == PIW'(k));
        end
    end

    // Hit decision for the visited pair, next claim vectors and FIFO pointer steps.
    always_comb begin
        w_hit = (r_state == S_SCAN)
              & (|(r_snap & w_psel))
              & ~(|(r_tclaim & w_tsel))
              & ~(|(r_rclaim & w_rsel));
        w_push = w_hit & (r_cnt < CW'(DEPTH));
        if (w_push) begin
            w_tclaim_nxt = r_tclaim | w_tsel;
            w_rclaim_nxt = r_rclaim | w_rsel;
        end else begin
            w_tclaim_nxt = r_tclaim;
            w_rclaim_nxt = r_rclaim;
        end
        if (r_wr == AW'(DEPTH - 1)) begin
            w_wr_nxt = '0;
        end else begin
            w_wr_nxt = r_wr + AW'(1);
        end
        if (r_rd == AW'(DEPTH - 1)) begin
            w_rd_nxt = '0;
        end else begin
            w_rd_nxt = r_rd + AW'(1);
        end
    end

    // Resolution FSM: scan pairs, pulse the claims, drain the event FIFO;
    // a vsync from any state restarts the scan on the fresh snapshot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pidx     <= '0;
            r_ti       <= '0;
            r_rj       <= '0;
            r_tclaim   <= '0;
            r_rclaim   <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                r_fifo_t[k] <= '0;
                r_fifo_r[k] <= '0;
            end
            r_torp_hit <= '0;
            r_rock_hit <= '0;
            r_ship_hit <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev_torp  <= '0;
            r_ev_rock  <= '0;
            r_overrun  <= 1'b0;
        end else if (i_vsync) begin
            if (r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
            r_state    <= S_SCAN;
            r_pidx     <= '0;
            r_ti       <= '0;
            r_rj       <= '0;
            r_tclaim   <= '0;
            r_rclaim   <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_torp_hit <= '0;
            r_rock_hit <= '0;
            r_ship_hit <= 1'b0;
            r_ev_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_SCAN: begin
                    r_tclaim <= w_tclaim_nxt;
                    r_rclaim <= w_rclaim_nxt;
                    if (w_push) begin
                        r_fifo_t[r_wr] <= r_ti;
                        r_fifo_r[r_wr] <= r_rj;
                        r_wr           <= w_wr_nxt;
                        r_cnt          <= r_cnt + CW'(1);
                    end
                    if (r_pidx == PIW'(PAIRS - 1)) begin
                        r_pidx     <= '0;
                        r_ti       <= '0;
                        r_rj       <= '0;
                        r_state    <= S_PULSE;
                        r_torp_hit <= w_tclaim_nxt;
                        r_rock_hit <= w_rclaim_nxt;
                        r_ship_hit <= w_ship_snap;
                    end else begin
                        r_pidx <= r_pidx + PIW'(1);
                        if (r_rj == RW'(ROCKS - 1)) begin
                            r_rj <= '0;
                            r_ti <= r_ti + TW'(1);
                        end else begin
                            r_rj <= r_rj + RW'(1);
                        end
                    end
                end
                S_PULSE: begin
                    r_torp_hit <= '0;
                    r_rock_hit <= '0;
                    r_ship_hit <= 1'b0;
                    r_state    <= S_DRAIN;
                    if (r_cnt != '0) begin
                        r_ev_valid <= 1'b1;
                        r_ev_torp  <= r_fifo_t[r_rd];
                        r_ev_rock  <= r_fifo_r[r_rd];
                    end else begin
                        r_ev_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_ev_valid && ev_if.ev_ready) begin
                        r_rd  <= w_rd_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_ev_valid <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_ev_valid <= 1'b1;
                            r_ev_torp  <= r_fifo_t[w_rd_nxt];
                            r_ev_rock  <= r_fifo_r[w_rd_nxt];
                        end
                    end else if (r_cnt == '0) begin
                        r_ev_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_torp_hit     = r_torp_hit;
    assign o_rock_hit     = r_rock_hit;
    assign o_ship_hit     = r_ship_hit;
    assign o_overrun      = r_overrun;
    assign o_busy         = (r_state != S_IDLE);
    assign ev_if.ev_valid = r_ev_valid;
    assign ev_if.ev_torp  = r_ev_torp;
    assign ev_if.ev_rock  = r_ev_rock;
endmodule
